right_shift_reg: RTL and testbench
==================================

# right_shift_reg

Parallel-load, serial-in right-shift register of parameterizable width. It is used wherever a word must be captured in one cycle and then serialized LSB-first, with new bits entering from the MSB side. It is a single-clock-domain leaf block with an asynchronous active-low reset. It has no handshake; the controlling logic drives the load/enable strobes directly.

## Interface
- DW, default 4: register width in bits, legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock; all state changes except reset occur on its rising edge.
- async_rst_n  input  1  asynchronous reset, active-low. Assertion clears q immediately. Deassertion is released on the next clk edge with no other effect.
- load  input  1  parallel-load strobe, active-high.
- en  input  1  shift-enable strobe, active-high.
- data  input  DW  parallel load word.
- data_h  input  1  serial input bit, entering at the MSB on each shift.
- q  output  DW  register contents, driven directly from flops.
- sout  output  1  serial output. Present only with RIGHT_SHIFT_REG_SOUT_EN defined; see Configuration.

## Operation
- State: a single DW-bit register that drives q. There is no FSM.
- Priority at each rising clk edge, while async_rst_n=1:
  - load=1: q ← data. This holds regardless of en, so load wins over shift.
  - load=0 and en=1: q ← {data_h, q[DW-1:1]}. q[0] is discarded (or presented on sout). data_h becomes the new MSB.
  - load=0 and en=0: q holds.
- Reset: async_rst_n=0 forces q=0 (and sout=0) immediately, independent of clk. This dominates load and en. Any load or shift in flight is lost.
- Continuous shifting with en=1 fills the register with data_h history. After DW shifts, the original contents are fully replaced.
- Widths: data is exactly DW bits. There is no extension or truncation.

## Timing
- Load latency: 1 cycle. The value on data at the rising edge appears on q right after that edge.
- Shift latency: 1 cycle per bit.
- Inputs are sampled only at the rising edge. Changes between edges have no effect.
- Reset value: q = 0 (and sout = 0).
- Reset mid-operation:
  - Reset asserted during a shift sequence clears q at once.
  - The first edge after release with load=1 loads normally.
- Simultaneous load=1 and en=1: a load is performed and no shift occurs.

## Configuration
- Macro RIGHT_SHIFT_REG_SOUT_EN.
- Defined:
  - Port sout exists and equals q[0] combinationally, i.e. the bit that the next shift will discard.
  - An LSB-first serial stream is therefore available: first bit right after load, then one new bit per enabled shift.
- Undefined:
  - Port sout is absent.
  - The q behaviour is identical in both builds.

## Test plan
1. Reset: drive async_rst_n=0 for 3 ns mid-cycle, with load=0 and en=0. Require q=0 immediately, before any clk edge, and q stays 0 after release while idle.
2. Load and hold (DW=4): load=1 with data=4'b1011 for one edge, then load=0 and en=0 for 5 cycles. Require q=4'b1011 after the edge, unchanged for all 5 cycles despite data toggling randomly.
3. Shift:
   - Start: q=4'b1011, then en=1 and load=0 with data_h sequence 1,0,0,1.
   - Require q after each edge: 4'b1101, 4'b0110, 4'b0011, 4'b1001.
4. Priority: q=4'b0110, then load=1, en=1, data=4'b1100, data_h=1. Require q=4'b1100 after one edge, with no shift applied.
5. Reset mid-shift: en=1 shifting with q=4'b1111, then pulse async_rst_n=0 for 4 ns between edges. Require q=0 during the pulse. On the next edge after release, with load=1 and data=4'b0101, require q=4'b0101.
6. With RIGHT_SHIFT_REG_SOUT_EN: load 4'b1011, then shift 4 times with en=1. Require sout sequence 1,1,0,1: after the load, then after each of the first 3 shifts.

Source files
------------

// File: rtl/right_shift_reg.sv
// Parallel-load, serial-in right-shift register; new bits enter at the MSB, old bits leave at the LSB.
// Optional serial output port sout is built when RIGHT_SHIFT_REG_SOUT_EN is defined.
module right_shift_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] data,
    input  logic          data_h,
`ifdef RIGHT_SHIFT_REG_SOUT_EN
    output logic          sout,
`endif
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_q_next;

    // Load has priority over shift; with neither strobe the contents hold.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = data;
        end else if (en) begin
            w_q_next = {data_h, r_q[DW-1:1]};
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

`ifdef RIGHT_SHIFT_REG_SOUT_EN
    // The bit the next shift will discard, giving an LSB-first stream.
    assign sout = r_q[0];
`endif

endmodule

// File: tb/tb_right_shift_reg.sv
// Self-checking bench for right_shift_reg: directed scenarios plus randomized traffic
// compared against an arithmetic model of the register contents.
module tb_right_shift_reg;

    localparam int DW = 4;

    logic          clk;
    logic          async_rst_n;
    logic          load;
    logic          en;
    logic [DW-1:0] data;
    logic          data_h;
    logic [DW-1:0] q;
`ifdef RIGHT_SHIFT_REG_SOUT_EN
    logic          sout;
`endif

    int n_checks;
    int n_errors;
    logic [DW-1:0] m_q;

    right_shift_reg #(.DW(DW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .load        (load),
        .en          (en),
        .data        (data),
        .data_h      (data_h),
`ifdef RIGHT_SHIFT_REG_SOUT_EN
        .sout        (sout),
`endif
        .q           (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a load replaces the word; a shift halves it and adds data_h as the top bit.
    function automatic logic [DW-1:0] model_next(input logic [DW-1:0] cur, input logic ld,
                                                 input logic e, input logic [DW-1:0] d,
                                                 input logic dh);
        int v;
        if (ld) return d;
        if (e) begin
            v = (int'(cur) / 2) + (dh ? (1 << (DW - 1)) : 0);
            return v[DW-1:0];
        end
        return cur;
    endfunction

    // Drives inputs away from the edge, clocks once, samples 1 ns after the edge.
    task automatic cycle(input string name, input logic ld, input logic e,
                         input logic [DW-1:0] d, input logic dh);
        load   = ld;
        en     = e;
        data   = d;
        data_h = dh;
        m_q    = model_next(m_q, ld, e, d, dh);
        @(posedge clk);
        #1;
        n_checks++;
        if (q !== m_q) begin
            n_errors++;
            $display("FAIL %s: q=%b expected %b", name, q, m_q);
        end
    endtask

    task automatic test_reset();
        load = 1'b0; en = 1'b0; data = '0; data_h = 1'b0;
        async_rst_n = 1'b1;
        @(posedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== '0) begin
            n_errors++;
            $display("FAIL reset_immediate: q=%b expected %b", q, 4'b0000);
        end
        #2;
        async_rst_n = 1'b1;
        m_q = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) cycle("reset_idle", 1'b0, 1'b0, DW'($urandom), 1'($urandom));
    endtask

    task automatic test_load_hold();
        cycle("load", 1'b1, 1'b0, 4'b1011, 1'($urandom));
        n_checks++;
        if (q !== 4'b1011) begin
            n_errors++;
            $display("FAIL load_value: q=%b expected %b", q, 4'b1011);
        end
        for (int i = 0; i < 5; i++) cycle("hold", 1'b0, 1'b0, DW'($urandom), 1'($urandom));
    endtask

    task automatic test_shift();
        logic [3:0] exp_q [4];
        logic       dh_seq [4];
        exp_q  = '{4'b1101, 4'b0110, 4'b0011, 4'b1001};
        dh_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        cycle("shift_preload", 1'b1, 1'b0, 4'b1011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle("shift_model", 1'b0, 1'b1, DW'($urandom), dh_seq[i]);
            n_checks++;
            if (q !== exp_q[i]) begin
                n_errors++;
                $display("FAIL shift_step%0d: q=%b expected %b", i, q, exp_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        cycle("prio_preload", 1'b1, 1'b0, 4'b0110, 1'b0);
        cycle("prio_model", 1'b1, 1'b1, 4'b1100, 1'b1);
        n_checks++;
        if (q !== 4'b1100) begin
            n_errors++;
            $display("FAIL priority: q=%b expected %b", q, 4'b1100);
        end
    endtask

    task automatic test_reset_mid_shift();
        cycle("mid_preload", 1'b1, 1'b0, 4'b1111, 1'b1);
        cycle("mid_shift", 1'b0, 1'b1, 4'b0000, 1'b1);
        #2;
        async_rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_pulse: q=%b expected %b", q, 4'b0000);
        end
        #3;
        async_rst_n = 1'b1;
        m_q = '0;
        cycle("mid_reload", 1'b1, 1'b1, 4'b0101, 1'b1);
        n_checks++;
        if (q !== 4'b0101) begin
            n_errors++;
            $display("FAIL mid_reload_value: q=%b expected %b", q, 4'b0101);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            cycle("random", 1'($urandom_range(0, 3) == 0), 1'($urandom), DW'($urandom), 1'($urandom));
`ifdef RIGHT_SHIFT_REG_SOUT_EN
            n_checks++;
            if (sout !== m_q[0]) begin
                n_errors++;
                $display("FAIL random_sout: sout=%b expected %b", sout, m_q[0]);
            end
`endif
        end
    endtask

`ifdef RIGHT_SHIFT_REG_SOUT_EN
    task automatic test_sout();
        logic exp_s [4];
        exp_s = '{1'b1, 1'b1, 1'b0, 1'b1};
        cycle("sout_load", 1'b1, 1'b0, 4'b1011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sout !== exp_s[i]) begin
                n_errors++;
                $display("FAIL sout_seq%0d: sout=%b expected %b", i, sout, exp_s[i]);
            end
            cycle("sout_shift", 1'b0, 1'b1, 4'b0000, 1'($urandom));
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_q = '0;
        test_reset();
        test_load_hold();
        test_shift();
        test_priority();
        test_reset_mid_shift();
`ifdef RIGHT_SHIFT_REG_SOUT_EN
        test_sout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
